// File: rtl/fft_cmul_twiddle_pipe_if.sv
// Sample/twiddle bundle into the complex multiplier and result bundle out of it.
// master drives samples and ce; slave is the multiplier.
interface fft_cmul_twiddle_pipe_if #(
  parameter int DIN_W  = 20,
  parameter int TW_W   = 16,
  parameter int DOUT_W = 20
);
  logic                     ce;
  logic                     in_valid;
  logic                     conj;
  logic signed [DIN_W-1:0]  x_re;
  logic signed [DIN_W-1:0]  x_im;
  logic signed [TW_W-1:0]   w_re;
  logic signed [TW_W-1:0]   w_im;
  logic                     out_valid;
  logic signed [DOUT_W-1:0] y_re;
  logic signed [DOUT_W-1:0] y_im;
  logic                     ovf;

  modport master (
    output ce, in_valid, conj, x_re, x_im, w_re, w_im,
    input  out_valid, y_re, y_im, ovf
  );

  modport slave (
    input  ce, in_valid, conj, x_re, x_im, w_re, w_im,
    output out_valid, y_re, y_im, ovf
  );
endinterface

// File: rtl/fft_cmul_twiddle_pipe.sv
// Pipelined twiddle multiplier y = x*w or x*conj(w), half-up rounding and saturation; latency 4+EXTRA_STAGES ce cycles.
// No backpressure: ce=0 freezes every stage and any input offered during ce=0 is ignored.
module fft_cmul_twiddle_pipe #(
  parameter int DIN_W        = 20,
  parameter int TW_W         = 16,
  parameter int DOUT_W       = 20,
  parameter int SHIFT        = 15,
  parameter int EXTRA_STAGES = 0
) (
  input logic                    clk,
  input logic                    rst_n,
  fft_cmul_twiddle_pipe_if.slave bus
);
  localparam int PW = DIN_W + TW_W + 1;
  localparam int P  = PW + 1;
  localparam int RW = P + 1;
  localparam logic signed [RW-1:0] RND = {{(RW-1){1'b0}}, 1'b1} <<< (SHIFT - 1);

  generate
    if (SHIFT < 1 || SHIFT > DIN_W + TW_W - 1) begin : g_bad_shift
      $error("fft_cmul_twiddle_pipe: SHIFT out of range");
    end
    if (EXTRA_STAGES < 0 || EXTRA_STAGES > 4) begin : g_bad_extra
      $error("fft_cmul_twiddle_pipe: EXTRA_STAGES out of range");
    end
    if (DOUT_W < 2 || DOUT_W > P) begin : g_bad_dout
      $error("fft_cmul_twiddle_pipe: DOUT_W out of range");
    end
  endgenerate

  // Returns {sat_flag, clamped value}.
  function automatic logic [DOUT_W:0] sat(input logic signed [RW-1:0] r);
    logic [RW-DOUT_W:0] hi;
    hi = r[RW-1:DOUT_W-1];
    if (&hi || ~|hi)   sat = {1'b0, r[DOUT_W-1:0]};
    else if (r[RW-1])  sat = {1'b1, 1'b1, {(DOUT_W-1){1'b0}}};
    else               sat = {1'b1, 1'b0, {(DOUT_W-1){1'b1}}};
  endfunction

  logic                    v1_q, v2_q, v3_q, v4_q;
  logic signed [DIN_W-1:0] xr1_q, xi1_q;
  logic signed [TW_W-1:0]  wr1_q;
  logic signed [TW_W:0]    wi_ext, wi1_d, wi1_q;
  logic signed [PW-1:0]    xr_e, xi_e, wr_e, wi_e;
  logic signed [PW-1:0]    pr_d, pi_d, qr_d, qi_d;
  logic signed [PW-1:0]    pr_q, pi_q, qr_q, qi_q;
  logic signed [P-1:0]     re3_d, im3_d, re3_q, im3_q;
  logic signed [RW-1:0]    rre, rim;
  logic [DOUT_W:0]         sre, sim;
  logic [DOUT_W-1:0]       yr4_q, yi4_q;
  logic                    ovf4_q;

  // One extra bit so that negating the most negative twiddle is exact.
  assign wi_ext = (TW_W+1)'(bus.w_im);
  assign wi1_d  = bus.conj ? -wi_ext : wi_ext;

  assign xr_e = PW'(xr1_q);
  assign xi_e = PW'(xi1_q);
  assign wr_e = PW'(wr1_q);
  assign wi_e = PW'(wi1_q);
  assign pr_d = xr_e * wr_e;
  assign pi_d = xi_e * wi_e;
  assign qr_d = xr_e * wi_e;
  assign qi_d = xi_e * wr_e;

  assign re3_d = P'(pr_q) - P'(pi_q);
  assign im3_d = P'(qr_q) + P'(qi_q);

  assign rre = (RW'(re3_q) + RND) >>> SHIFT;
  assign rim = (RW'(im3_q) + RND) >>> SHIFT;
  assign sre = sat(rre);
  assign sim = sat(rim);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0; v4_q <= 1'b0;
      xr1_q <= '0; xi1_q <= '0; wr1_q <= '0; wi1_q <= '0;
      pr_q <= '0; pi_q <= '0; qr_q <= '0; qi_q <= '0;
      re3_q <= '0; im3_q <= '0;
      yr4_q <= '0; yi4_q <= '0; ovf4_q <= 1'b0;
    end else if (bus.ce) begin
      v1_q   <= bus.in_valid;
      xr1_q  <= bus.x_re;
      xi1_q  <= bus.x_im;
      wr1_q  <= bus.w_re;
      wi1_q  <= wi1_d;
      v2_q   <= v1_q;
      pr_q   <= pr_d;
      pi_q   <= pi_d;
      qr_q   <= qr_d;
      qi_q   <= qi_d;
      v3_q   <= v2_q;
      re3_q  <= re3_d;
      im3_q  <= im3_d;
      v4_q   <= v3_q;
      yr4_q  <= sre[DOUT_W-1:0];
      yi4_q  <= sim[DOUT_W-1:0];
      ovf4_q <= sre[DOUT_W] | sim[DOUT_W];
    end
  end

  generate
    if (EXTRA_STAGES == 0) begin : g_no_extra
      assign bus.out_valid = v4_q;
      assign bus.y_re      = $signed(yr4_q);
      assign bus.y_im      = $signed(yi4_q);
      assign bus.ovf       = ovf4_q;
    end else begin : g_extra
      logic [EXTRA_STAGES-1:0]             ve_q, ovfe_q;
      logic [EXTRA_STAGES-1:0][DOUT_W-1:0] yre_q, yie_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ve_q   <= '0;
          ovfe_q <= '0;
          yre_q  <= '0;
          yie_q  <= '0;
        end else if (bus.ce) begin
          ve_q[0]   <= v4_q;
          ovfe_q[0] <= ovf4_q;
          yre_q[0]  <= yr4_q;
          yie_q[0]  <= yi4_q;
          for (int i = 1; i < EXTRA_STAGES; i++) begin
            ve_q[i]   <= ve_q[i-1];
            ovfe_q[i] <= ovfe_q[i-1];
            yre_q[i]  <= yre_q[i-1];
            yie_q[i]  <= yie_q[i-1];
          end
        end
      end

      assign bus.out_valid = ve_q[EXTRA_STAGES-1];
      assign bus.y_re      = $signed(yre_q[EXTRA_STAGES-1]);
      assign bus.y_im      = $signed(yie_q[EXTRA_STAGES-1]);
      assign bus.ovf       = ovfe_q[EXTRA_STAGES-1];
    end
  endgenerate
endmodule

// File: tb/tb_fft_cmul_twiddle_pipe.sv
// Directed bench for the twiddle multiplier: one instance with EXTRA_STAGES=0 and one with 2, fed identically.
module tb_fft_cmul_twiddle_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               ce, in_valid, conj;
  logic signed [19:0] x_re, x_im;
  logic signed [15:0] w_re, w_im;

  fft_cmul_twiddle_pipe_if #(.DIN_W(20), .TW_W(16), .DOUT_W(20)) if0 ();
  fft_cmul_twiddle_pipe_if #(.DIN_W(20), .TW_W(16), .DOUT_W(20)) if2 ();

  assign if0.ce = ce;   assign if0.in_valid = in_valid; assign if0.conj = conj;
  assign if0.x_re = x_re; assign if0.x_im = x_im; assign if0.w_re = w_re; assign if0.w_im = w_im;
  assign if2.ce = ce;   assign if2.in_valid = in_valid; assign if2.conj = conj;
  assign if2.x_re = x_re; assign if2.x_im = x_im; assign if2.w_re = w_re; assign if2.w_im = w_im;

  fft_cmul_twiddle_pipe #(.DIN_W(20), .TW_W(16), .DOUT_W(20), .SHIFT(15), .EXTRA_STAGES(0))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  fft_cmul_twiddle_pipe #(.DIN_W(20), .TW_W(16), .DOUT_W(20), .SHIFT(15), .EXTRA_STAGES(2))
    u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int xr, input int xi, input int wr, input int wi, input bit cj, input bit v);
    x_re = 20'(xr); x_im = 20'(xi); w_re = 16'(wr); w_im = 16'(wi); conj = cj; in_valid = v;
  endtask

  function automatic void satv(input longint r, output longint y, output bit o);
    if (r > 524287)       begin y = 524287;  o = 1'b1; end
    else if (r < -524288) begin y = -524288; o = 1'b1; end
    else                  begin y = r;       o = 1'b0; end
  endfunction

  function automatic void model(input longint xr, input longint xi, input longint wr, input longint wi,
                                input bit cj, output longint yr, output longint yi, output bit o);
    longint we, sr, si;
    bit     or_, oi;
    we = cj ? -wi : wi;
    sr = xr * wr - xi * we;
    si = xr * we + xi * wr;
    satv((sr + 16384) >>> 15, yr, or_);
    satv((si + 16384) >>> 15, yi, oi);
    o = or_ | oi;
  endfunction

  // One isolated sample: idle for 3 edges after capture, valid on the 4th.
  task automatic run_vec(input string tag, input int xr, input int xi, input int wr, input int wi,
                         input bit cj, input longint er, input longint ei, input longint eo);
    drive(xr, xi, wr, wi, cj, 1'b1);
    step();
    drive(0, 0, 0, 0, 1'b0, 1'b0);
    step();
    step();
    check({tag, "_early_vld"}, if0.out_valid, 0);
    step();
    check({tag, "_vld"}, if0.out_valid, 1);
    check({tag, "_yre"}, if0.y_re, er);
    check({tag, "_yim"}, if0.y_im, ei);
    check({tag, "_ovf"}, if0.ovf, eo);
    step();
  endtask

  int sx_re[16], sx_im[16], sw_re[16], sw_im[16];
  bit scj[16];
  bit     mv[0:5], mo[0:5];
  longint mre[0:5], mim[0:5];

  initial begin
    int cnt0, cnt2, k;
    longint nr, ni;
    bit no;
    ce = 1'b1;
    drive(0, 0, 0, 0, 1'b0, 1'b0);
    #2;
    check("reset_vld0", if0.out_valid, 0);
    check("reset_yre0", if0.y_re, 0);
    check("reset_ovf0", if0.ovf, 0);
    check("reset_vld2", if2.out_valid, 0);
    #10 rst_n = 1'b1;
    repeat (3) step();

    run_vec("scale",    1000,   0,      16384,  0,      1'b0, 500,  0,       0);
    run_vec("rnd_pos",  3,      0,      16384,  0,      1'b0, 2,    0,       0);
    run_vec("rnd_neg",  -3,     0,      16384,  0,      1'b0, -1,   0,       0);
    run_vec("cplx",     100,    200,    0,      16384,  1'b0, -100, 50,      0);
    run_vec("conj",     100,    200,    0,      16384,  1'b1, 100,  -50,     0);
    run_vec("sat",      524287, 524287, -32768, -32768, 1'b0, 0,    -524288, 1);
    run_vec("post_sat", 1000,   0,      16384,  0,      1'b0, 500,  0,       0);

    // Reset mid-stream: everything in flight must vanish.
    drive(1000, 0, 16384, 0, 1'b0, 1'b1);
    repeat (5) step();
    check("rst_pre_vld", if0.out_valid, 1);
    check("rst_pre_yre", if0.y_re, 500);
    rst_n = 1'b0;
    #1;
    check("rst_vld0", if0.out_valid, 0);
    check("rst_yre0", if0.y_re, 0);
    check("rst_yim0", if0.y_im, 0);
    check("rst_ovf0", if0.ovf, 0);
    check("rst_vld2", if2.out_valid, 0);
    check("rst_yre2", if2.y_re, 0);
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    cnt0 = 0;
    cnt2 = 0;
    repeat (10) begin
      step();
      cnt0 += int'(if0.out_valid);
      cnt2 += int'(if2.out_valid);
    end
    check("rst_flush0", cnt0, 0);
    check("rst_flush2", cnt2, 0);

    // Streaming with a 3-cycle ce stall, checked every cycle against a delay-line model.
    for (int i = 0; i < 16; i++) begin
      sx_re[i] = int'($urandom_range(1048575)) - 524288;
      sx_im[i] = int'($urandom_range(1048575)) - 524288;
      sw_re[i] = int'($urandom_range(65535)) - 32768;
      sw_im[i] = int'($urandom_range(65535)) - 32768;
      scj[i]   = 1'($urandom_range(1));
    end
    sx_re[5] = 524287; sx_im[5] = 524287; sw_re[5] = -32768; sw_im[5] = -32768; scj[5] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      mv[i] = 1'b0; mo[i] = 1'b0; mre[i] = 0; mim[i] = 0;
    end
    k = 0;
    cnt0 = 0;
    cnt2 = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      ce = !(cyc >= 8 && cyc < 11);
      if (k < 16) drive(sx_re[k], sx_im[k], sw_re[k], sw_im[k], scj[k], 1'b1);
      else        drive(0, 0, 0, 0, 1'b0, 1'b0);
      step();
      if (ce) begin
        for (int j = 5; j > 0; j--) begin
          mv[j] = mv[j-1]; mo[j] = mo[j-1]; mre[j] = mre[j-1]; mim[j] = mim[j-1];
        end
        mv[0] = in_valid;
        if (in_valid) begin
          model(sx_re[k], sx_im[k], sw_re[k], sw_im[k], scj[k], nr, ni, no);
          mre[0] = nr; mim[0] = ni; mo[0] = no;
          k++;
        end
        if (if0.out_valid) cnt0++;
        if (if2.out_valid) cnt2++;
      end
      check("strm_vld0", if0.out_valid, longint'(mv[3]));
      if (mv[3]) begin
        check("strm_yre0", if0.y_re, mre[3]);
        check("strm_yim0", if0.y_im, mim[3]);
        check("strm_ovf0", if0.ovf, longint'(mo[3]));
      end
      check("strm_vld2", if2.out_valid, longint'(mv[5]));
      if (mv[5]) begin
        check("strm_yre2", if2.y_re, mre[5]);
        check("strm_yim2", if2.y_im, mim[5]);
        check("strm_ovf2", if2.ovf, longint'(mo[5]));
      end
    end
    check("strm_count0", cnt0, 16);
    check("strm_count2", cnt2, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
